// File: rtl/tile_write_arbiter_if.sv
// Bus bundle for tile_write_arbiter: table-fill control, two write requesters and the
// table write port. master = requesters/fill controller side, slave = arbiter side.
interface tile_write_arbiter_if #(
    parameter int unsigned addr_width = 11,
    parameter int unsigned nsprites   = 4
);
    logic                  clr_req;
    logic [nsprites-1:0]   clr_tile;
    logic                  clr_busy;
    logic                  clr_done;

    logic                  req0;
    logic                  req1;
    logic [addr_width-1:0] addr0;
    logic [addr_width-1:0] addr1;
    logic [nsprites-1:0]   data0;
    logic [nsprites-1:0]   data1;
    logic                  ack0;
    logic                  ack1;

    logic                  ram_we;
    logic [addr_width-1:0] ram_waddr;
    logic [nsprites-1:0]   ram_din;
    logic [15:0]           wr_count;

    modport master (
        output clr_req, clr_tile, req0, req1, addr0, addr1, data0, data1,
        input  clr_busy, clr_done, ack0, ack1, ram_we, ram_waddr, ram_din, wr_count
    );

    modport slave (
        input  clr_req, clr_tile, req0, req1, addr0, addr1, data0, data1,
        output clr_busy, clr_done, ack0, ack1, ram_we, ram_waddr, ram_din, wr_count
    );
endinterface

// File: rtl/tile_write_arbiter.sv
// Round-robin arbiter for two tile-table writers plus a whole-table fill mode.
// Define WRITE_COUNT_EN to add a saturating 16-bit count of granted requester writes.
module tile_write_arbiter #(
    parameter int unsigned rows       = 30,
    parameter int unsigned cols       = 40,
    parameter int unsigned addr_width = 11,
    parameter int unsigned nsprites   = 4
) (
    input logic                 clk,
    input logic                 rstn,
    tile_write_arbiter_if.slave bus
);
    localparam int unsigned cells = rows * cols;
    localparam logic [addr_width-1:0] last_addr = addr_width'(cells - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                state_q, state_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic [nsprites-1:0]   din_q, din_d;
    logic [nsprites-1:0]   tile_q, tile_d;
    logic                  prio_q, prio_d;  // 1: requester 1 wins a tie

    logic elig0, elig1, grant1, in_range0, in_range1;

    // A requester acked this cycle is still holding req for the write just done.
    assign elig0     = bus.req0 & ~ack0_q;
    assign elig1     = bus.req1 & ~ack1_q;
    assign grant1    = elig1 & (~elig0 | prio_q);
    assign in_range0 = 32'(bus.addr0) < cells;
    assign in_range1 = 32'(bus.addr1) < cells;

    always_comb begin
        state_d = state_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        waddr_d = waddr_q;
        din_d   = din_q;
        tile_d  = tile_q;
        prio_d  = prio_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    tile_d  = bus.clr_tile;
                    busy_d  = 1'b1;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    din_d   = bus.clr_tile;
                end else if (elig0 | elig1) begin
                    if (grant1) begin
                        ack1_d  = 1'b1;
                        we_d    = in_range1;
                        waddr_d = bus.addr1;
                        din_d   = bus.data1;
                        prio_d  = 1'b0;
                    end else begin
                        ack0_d  = 1'b1;
                        we_d    = in_range0;
                        waddr_d = bus.addr0;
                        din_d   = bus.data0;
                        prio_d  = 1'b1;
                    end
                end
            end
            StClear: begin
                // waddr_q doubles as the fill cursor; clr_req is ignored here.
                if (waddr_q == last_addr) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + addr_width'(1);
                    din_d   = tile_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
            tile_q  <= '0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            tile_q  <= tile_d;
            prio_q  <= prio_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_waddr = waddr_q;
    assign bus.ram_din   = din_q;
    assign bus.clr_busy  = busy_q;
    assign bus.clr_done  = done_q;

`ifdef WRITE_COUNT_EN
    logic [15:0] count_q;

    // Counts the grant visible on the outputs; fill writes never carry an ack.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else if ((ack0_q | ack1_q) & we_q & (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.wr_count = count_q;
`else
    assign bus.wr_count = '0;
`endif
endmodule

// File: tb/tb_tile_write_arbiter.sv
// Self-checking bench for tile_write_arbiter: directed vector table, fill/reset sequences
// and a randomized run against a cycle-level reference model.
module tb_tile_write_arbiter;
    localparam int Rows  = 30;
    localparam int Cols  = 40;
    localparam int AW    = 11;
    localparam int NS    = 4;
    localparam int Cells = Rows * Cols;
`ifdef WRITE_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    tile_write_arbiter_if #(.addr_width(AW), .nsprites(NS)) bus ();

    tile_write_arbiter #(
        .rows(Rows), .cols(Cols), .addr_width(AW), .nsprites(NS)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rstn;
        bit req0; int addr0; int data0;
        bit req1; int addr1; int data1;
        bit ack0; bit ack1; bit we; int waddr; int din;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rn, bit r0, int a0, int d0, bit r1, int a1, int d1,
                                bit k0, bit k1, bit we, int wa, int di);
        vec_t v;
        v.rstn = rn; v.req0 = r0; v.addr0 = a0; v.data0 = d0;
        v.req1 = r1; v.addr1 = a1; v.data1 = d1;
        v.ack0 = k0; v.ack1 = k1; v.we = we; v.waddr = wa; v.din = di;
        return v;
    endfunction

    // Reference model: expected outputs after the next edge, from the arbitration rules.
    bit m_clear;
    int m_next, m_tile, m_last, m_cnt;
    bit e_ack0, e_ack1, e_we, e_busy, e_done;
    int e_waddr, e_din;

    task automatic model_edge();
        bit w0, w1;
        int w;
        if (!rstn) begin
            m_clear = 0; m_last = 1; m_cnt = 0;
            e_ack0 = 0; e_ack1 = 0; e_we = 0; e_busy = 0; e_done = 0;
            e_waddr = 0; e_din = 0;
            return;
        end
        if ((e_ack0 || e_ack1) && e_we && m_cnt < 65535) m_cnt++;
        w0 = bus.req0 && !e_ack0;
        w1 = bus.req1 && !e_ack1;
        e_ack0 = 0; e_ack1 = 0; e_we = 0; e_done = 0;
        if (m_clear) begin
            if (m_next == Cells) begin
                m_clear = 0; e_busy = 0; e_done = 1;
            end else begin
                e_we = 1; e_waddr = m_next; e_din = m_tile; m_next++;
            end
        end else if (bus.clr_req) begin
            m_clear = 1; m_tile = int'(bus.clr_tile); m_next = 1;
            e_busy = 1; e_we = 1; e_waddr = 0; e_din = m_tile;
        end else if (w0 || w1) begin
            if (w0 && w1) w = (m_last == 0) ? 1 : 0;
            else w = w0 ? 0 : 1;
            m_last = w;
            if (w == 0) begin
                e_ack0 = 1; e_waddr = int'(bus.addr0); e_din = int'(bus.data0);
            end else begin
                e_ack1 = 1; e_waddr = int'(bus.addr1); e_din = int'(bus.data1);
            end
            e_we = e_waddr < Cells;
        end
    endtask

    initial begin
        int errs;
        int exp_cnt;

        rstn = 0;
        bus.clr_req = 0; bus.clr_tile = '0;
        bus.req0 = 0; bus.addr0 = '0; bus.data0 = '0;
        bus.req1 = 0; bus.addr1 = '0; bus.data1 = '0;

        // ---- directed vector table, one row per clock ----
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 3, 0, 0, 0,       1, 0, 1, 5, 3));
        tbl.push_back(mk(1, 1, 5, 3, 0, 0, 0,       0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 3, 0, 0, 0,       1, 0, 1, 5, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 7, 9,       0, 1, 1, 7, 9));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1200, 2, 0, 0, 0,    1, 0, 0, 1200, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1199, 15, 0, 0, 0,   1, 0, 1, 1199, 15));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 4,       0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 4,       1, 0, 1, 2, 1));
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 4,       0, 1, 1, 3, 4));
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 4,       1, 0, 1, 2, 1));
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 4,       0, 1, 1, 3, 4));
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 4,       1, 0, 1, 2, 1));
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 4,       0, 1, 1, 3, 4));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2047, 6,    0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2047, 6,    0, 1, 0, 2047, 6));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 10, 1, 1, 11, 2,     1, 0, 1, 10, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            rstn      = tbl[i].rstn;
            bus.req0  = tbl[i].req0; bus.addr0 = AW'(tbl[i].addr0); bus.data0 = NS'(tbl[i].data0);
            bus.req1  = tbl[i].req1; bus.addr1 = AW'(tbl[i].addr1); bus.data1 = NS'(tbl[i].data1);
            tick();
            check($sformatf("tbl[%0d].ack0", i), 32'(bus.ack0), 32'(tbl[i].ack0));
            check($sformatf("tbl[%0d].ack1", i), 32'(bus.ack1), 32'(tbl[i].ack1));
            check($sformatf("tbl[%0d].ram_we", i), 32'(bus.ram_we), 32'(tbl[i].we));
            check($sformatf("tbl[%0d].clr_busy", i), 32'(bus.clr_busy), 32'd0);
            check($sformatf("tbl[%0d].clr_done", i), 32'(bus.clr_done), 32'd0);
            if (!tbl[i].rstn || tbl[i].ack0 || tbl[i].ack1 || tbl[i].we) begin
                check($sformatf("tbl[%0d].ram_waddr", i), 32'(bus.ram_waddr), 32'(tbl[i].waddr));
                check($sformatf("tbl[%0d].ram_din", i), 32'(bus.ram_din), 32'(tbl[i].din));
            end
            if (!tbl[i].rstn) check($sformatf("tbl[%0d].wr_count", i), 32'(bus.wr_count), 32'd0);
        end
        // Rows 10..15 and 19 are in-range grants after the last reset.
        check("tbl.wr_count", 32'(bus.wr_count), CountEn ? 32'd7 : 32'd0);

        // ---- three grants, then fill raced against req1, second clr_req ignored ----
        rstn = 0; bus.req0 = 0; bus.req1 = 0;
        tick();
        rstn = 1;
        bus.req0 = 1; bus.addr0 = AW'(1); bus.data0 = NS'(1);
        repeat (6) tick();
        bus.req0 = 0;
        tick();
        bus.clr_req = 1; bus.clr_tile = NS'(4'hA);
        bus.req1 = 1; bus.addr1 = AW'(9); bus.data1 = NS'(5);
        tick();
        bus.clr_req = 0;
        check("fill.first_we", 32'(bus.ram_we), 32'd1);
        check("fill.first_addr", 32'(bus.ram_waddr), 32'd0);
        check("fill.first_din", 32'(bus.ram_din), 32'hA);
        check("fill.first_busy", 32'(bus.clr_busy), 32'd1);
        check("fill.first_ack1", 32'(bus.ack1), 32'd0);
        errs = 0;
        for (int i = 1; i < Cells; i++) begin
            if (i == 600) begin
                bus.clr_req = 1; bus.clr_tile = NS'(3);
            end
            tick();
            bus.clr_req = 0;
            if (bus.ram_we !== 1'b1 || int'(bus.ram_waddr) != i || bus.ram_din !== NS'(4'hA) ||
                bus.clr_busy !== 1'b1 || bus.clr_done !== 1'b0 ||
                bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) errs++;
        end
        check("fill.bad_cycles", 32'(errs), 32'd0);
        tick();
        check("fill.done_pulse", 32'(bus.clr_done), 32'd1);
        check("fill.busy_fall", 32'(bus.clr_busy), 32'd0);
        check("fill.we_after", 32'(bus.ram_we), 32'd0);
        check("fill.ack1_at_done", 32'(bus.ack1), 32'd0);
        check("fill.wr_count", 32'(bus.wr_count), CountEn ? 32'd3 : 32'd0);
        tick();
        bus.req1 = 0;
        check("fill.done_single", 32'(bus.clr_done), 32'd0);
        check("fill.ack1_after", 32'(bus.ack1), 32'd1);
        check("fill.ack1_addr", 32'(bus.ram_waddr), 32'd9);
        check("fill.ack1_din", 32'(bus.ram_din), 32'd5);
        check("fill.ack1_we", 32'(bus.ram_we), 32'd1);
        tick();
        check("fill.ack1_once", 32'(bus.ack1), 32'd0);
        check("fill.done_quiet", 32'(bus.clr_done), 32'd0);

        // ---- reset during fill write 600 ----
        bus.clr_req = 1; bus.clr_tile = NS'(7);
        tick();
        bus.clr_req = 0;
        repeat (600) tick();
        check("abort.addr600", 32'(bus.ram_waddr), 32'd600);
        check("abort.we600", 32'(bus.ram_we), 32'd1);
        rstn = 0;
        tick();
        rstn = 1;
        check("abort.we", 32'(bus.ram_we), 32'd0);
        check("abort.busy", 32'(bus.clr_busy), 32'd0);
        check("abort.done", 32'(bus.clr_done), 32'd0);
        errs = 0;
        for (int i = 0; i < Cells + 100; i++) begin
            tick();
            if (bus.clr_done !== 1'b0 || bus.ram_we !== 1'b0 || bus.clr_busy !== 1'b0) errs++;
        end
        check("abort.quiet_cycles", 32'(errs), 32'd0);

        // ---- randomized run against the model ----
        rstn = 0;
        for (int n = 0; n < 6000; n++) begin
            if (n > 0) rstn = ($urandom_range(0, 599) != 0);
            bus.clr_req  = ($urandom_range(0, 499) == 0);
            bus.clr_tile = NS'($urandom);
            if (bus.req0 && e_ack0) begin
                if ($urandom_range(0, 1) == 1) bus.req0 = 0;
                else begin bus.addr0 = AW'($urandom); bus.data0 = NS'($urandom); end
            end else if (!bus.req0 && $urandom_range(0, 9) < 4) begin
                bus.req0 = 1; bus.addr0 = AW'($urandom); bus.data0 = NS'($urandom);
            end
            if (bus.req1 && e_ack1) begin
                if ($urandom_range(0, 1) == 1) bus.req1 = 0;
                else begin bus.addr1 = AW'($urandom); bus.data1 = NS'($urandom); end
            end else if (!bus.req1 && $urandom_range(0, 9) < 4) begin
                bus.req1 = 1; bus.addr1 = AW'($urandom); bus.data1 = NS'($urandom);
            end
            model_edge();
            tick();
            check($sformatf("rnd[%0d].ack0", n), 32'(bus.ack0), 32'(e_ack0));
            check($sformatf("rnd[%0d].ack1", n), 32'(bus.ack1), 32'(e_ack1));
            check($sformatf("rnd[%0d].ram_we", n), 32'(bus.ram_we), 32'(e_we));
            check($sformatf("rnd[%0d].clr_busy", n), 32'(bus.clr_busy), 32'(e_busy));
            check($sformatf("rnd[%0d].clr_done", n), 32'(bus.clr_done), 32'(e_done));
            exp_cnt = CountEn ? m_cnt : 0;
            check($sformatf("rnd[%0d].wr_count", n), 32'(bus.wr_count), 32'(exp_cnt));
            if (e_ack0 || e_ack1 || e_we) begin
                check($sformatf("rnd[%0d].ram_waddr", n), 32'(bus.ram_waddr), 32'(e_waddr));
                check($sformatf("rnd[%0d].ram_din", n), 32'(bus.ram_din), 32'(e_din));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
